// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle for alu_seq
interface alu_seq_if #(parameter int N = 32);
  logic         in_valid, in_ready, mul, out_valid, out_ready, overflow, zero, equal, busy;
  logic [N-1:0] a, b, result;
  logic [2:0]   control;
  modport master (
    output in_valid, a, b, control, mul, out_ready,
    input  in_ready, out_valid, result, overflow, zero, equal, busy
  );
  modport slave (
    input  in_valid, a, b, control, mul, out_ready,
    output in_ready, out_valid, result, overflow, zero, equal, busy
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with an iterative shift-add unsigned multiply
package alu_pkg;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_NOR} alu_control_t;
endpackage

module alu import alu_pkg::*; #(parameter int N = 32) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  alu_control_t control,
  output logic [N-1:0] y,
  output logic         overflow
);
  logic [N-1:0] sum, diff;
  assign sum  = a + b;
  assign diff = a - b;
  // overflow is the signed overflow of ADD/SUB; logic ops never overflow
  always_comb begin
    y        = '0;
    overflow = 1'b0;
    case (control)
      ALU_ADD: begin
        y        = sum;
        overflow = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      ALU_SUB: begin
        y        = diff;
        overflow = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLT: y = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR: y = ~(a | b);
      default: y = '0;
    endcase
  end
endmodule

module alu_seq import alu_pkg::*; #(parameter int N = 32) (
  input logic     clk,
  input logic     rst,
  alu_seq_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
  state_t         state, state_nxt;
  logic [2*N-1:0] mcand, acc, acc_nxt;
  logic [N-1:0]   mplier, alu_y;
  logic [CW-1:0]  cnt;
  logic           alu_ovf, accept, last, eq_q;
  alu #(.N(N)) u_alu (
    .a(bus.a), .b(bus.b), .control(alu_control_t'(bus.control)), .y(alu_y), .overflow(alu_ovf)
  );
  assign bus.in_ready  = (state == IDLE) | ((state == HOLD) & bus.out_ready);
  assign bus.out_valid = state == HOLD;
  assign bus.busy      = state == MUL;
  assign accept        = bus.in_valid & bus.in_ready;
  assign last          = (state == MUL) && (cnt == CW'(1));
  assign acc_nxt       = acc + (mplier[0] ? mcand : '0);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (accept)                                state_nxt = bus.mul ? MUL : HOLD;
    else if (last)                             state_nxt = HOLD;
    else if ((state == HOLD) && bus.out_ready) state_nxt = IDLE;
  end
  // a == b is captured at accept so the multiply needs no operand copies
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
      cnt          <= '0;
      eq_q         <= 1'b0;
      bus.result   <= '0;
      bus.overflow <= 1'b0;
      bus.zero     <= 1'b0;
      bus.equal    <= 1'b0;
    end else if (accept && !bus.mul) begin
      bus.result   <= alu_y;
      bus.overflow <= alu_ovf;
      bus.zero     <= alu_y == '0;
      bus.equal    <= bus.a == bus.b;
    end else if (accept) begin
      mcand  <= {{N{1'b0}}, bus.a};
      mplier <= bus.b;
      acc    <= '0;
      cnt    <= CW'(N);
      eq_q   <= bus.a == bus.b;
    end else if (state == MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      if (last) begin
        bus.result   <= acc_nxt[N-1:0];
        bus.overflow <= |acc_nxt[2*N-1:N];
        bus.zero     <= acc_nxt[N-1:0] == '0;
        bus.equal    <= eq_q;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table plus hand sequences for multiply, backpressure and reset
module tb_alu_seq;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_SLT = 3'd5, OP_NOR = 3'd6;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, r;
    logic        o, z, e;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;
  alu_seq_if #(.N(32)) b32();
  alu_seq_if #(.N(8))  b8();
  alu_seq #(.N(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  alu_seq #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  function automatic logic ov(input bit n8);
    return n8 ? b8.out_valid : b32.out_valid;
  endfunction
  task automatic alu_op(input string nm, input vec_t t);
    @(negedge clk);
    b32.control  = t.op;
    b32.a        = t.a;
    b32.b        = t.b;
    b32.mul      = 1'b0;
    b32.in_valid = 1'b1;
    @(posedge clk);
    #1;
    b32.in_valid = 1'b0;
    chk({nm, " valid"}, {31'b0, b32.out_valid}, 32'd1);
    chk({nm, " result"}, b32.result, t.r);
    chk({nm, " ovf"}, {31'b0, b32.overflow}, {31'b0, t.o});
    chk({nm, " zero"}, {31'b0, b32.zero}, {31'b0, t.z});
    chk({nm, " equal"}, {31'b0, b32.equal}, {31'b0, t.e});
  endtask
  task automatic mul_run(input string nm, input bit n8, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic o, input logic z, input logic e, input int lat_exp);
    int lat;
    @(negedge clk);
    if (n8) begin
      b8.a = a[7:0]; b8.b = b[7:0]; b8.mul = 1'b1; b8.in_valid = 1'b1;
    end else begin
      b32.a = a; b32.b = b; b32.mul = 1'b1; b32.in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    b8.in_valid = 1'b0; b8.mul = 1'b0; b32.in_valid = 1'b0; b32.mul = 1'b0;
    chk({nm, " busy"}, {31'b0, n8 ? b8.busy : b32.busy}, 32'd1);
    lat = 0;
    while (lat < 200 && !ov(n8)) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(lat_exp));
    chk({nm, " result"}, n8 ? {24'b0, b8.result} : b32.result, r);
    chk({nm, " ovf"}, {31'b0, n8 ? b8.overflow : b32.overflow}, {31'b0, o});
    chk({nm, " zero"}, {31'b0, n8 ? b8.zero : b32.zero}, {31'b0, z});
    chk({nm, " equal"}, {31'b0, n8 ? b8.equal : b32.equal}, {31'b0, e});
    chk({nm, " busy done"}, {31'b0, n8 ? b8.busy : b32.busy}, 32'd0);
  endtask
  vec_t v[10];
  vec_t s[4];
  initial begin
    bit seen;
    v[0] = '{OP_ADD, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0};
    v[1] = '{OP_ADD, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0};
    v[2] = '{OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 1'b1};
    v[3] = '{OP_SUB, 32'h80000000, 32'h00000001, 32'h7fffffff, 1'b1, 1'b0, 1'b0};
    v[4] = '{OP_AND, 32'hf0f0f0f0, 32'hff00ff00, 32'hf000f000, 1'b0, 1'b0, 1'b0};
    v[5] = '{OP_OR,  32'h0f0f0000, 32'h000000ff, 32'h0f0f00ff, 1'b0, 1'b0, 1'b0};
    v[6] = '{OP_XOR, 32'haaaaaaaa, 32'haaaaaaaa, 32'h00000000, 1'b0, 1'b1, 1'b1};
    v[7] = '{OP_SLT, 32'hffffffff, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
    v[8] = '{OP_NOR, 32'h00000000, 32'h00000000, 32'hffffffff, 1'b0, 1'b0, 1'b1};
    v[9] = '{OP_ADD, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0};
    s[0] = '{OP_AND, 32'h000000ff, 32'h00000011, 32'h00000011, 1'b0, 1'b0, 1'b0};
    s[1] = '{OP_AND, 32'h000000ff, 32'h00000022, 32'h00000022, 1'b0, 1'b0, 1'b0};
    s[2] = '{OP_AND, 32'h000000ff, 32'h00000133, 32'h00000033, 1'b0, 1'b0, 1'b0};
    s[3] = '{OP_AND, 32'h0000ff00, 32'h000000ff, 32'h00000000, 1'b0, 1'b1, 1'b0};
    b32.in_valid = 1'b0; b32.mul = 1'b0; b32.out_ready = 1'b1; b32.a = '0; b32.b = '0; b32.control = OP_ADD;
    b8.in_valid  = 1'b0; b8.mul  = 1'b0; b8.out_ready  = 1'b1; b8.a  = '0; b8.b  = '0; b8.control  = OP_ADD;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {31'b0, b32.out_valid}, 32'd0);
    chk("reset in_ready", {31'b0, b32.in_ready}, 32'd1);
    chk("reset busy", {31'b0, b32.busy}, 32'd0);
    chk("reset result", b32.result, 32'd0);
    chk("reset flags", {29'b0, b32.overflow, b32.zero, b32.equal}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) alu_op($sformatf("vec%0d", i), v[i]);
    alu_op("bp sub", '{OP_SUB, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 1'b1});
    @(negedge clk);
    b32.out_ready = 1'b0; b32.control = OP_ADD; b32.a = 32'd3; b32.b = 32'd4; b32.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d valid", i), {31'b0, b32.out_valid}, 32'd1);
      chk($sformatf("bp%0d result", i), b32.result, 32'd0);
      chk($sformatf("bp%0d flags", i), {29'b0, b32.overflow, b32.zero, b32.equal}, 32'b011);
      chk($sformatf("bp%0d in_ready", i), {31'b0, b32.in_ready}, 32'd0);
    end
    @(negedge clk);
    b32.out_ready = 1'b1;
    #1;
    chk("bp in_ready up", {31'b0, b32.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    b32.in_valid = 1'b0;
    chk("bp refill valid", {31'b0, b32.out_valid}, 32'd1);
    chk("bp refill result", b32.result, 32'd7);
    chk("bp refill flags", {29'b0, b32.overflow, b32.zero, b32.equal}, 32'd0);
    for (int i = 0; i < 4; i++) alu_op($sformatf("stream%0d", i), s[i]);
    @(posedge clk);
    #1;
    chk("stream drained", {31'b0, b32.out_valid}, 32'd0);
    mul_run("mul32 sq", 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b1, 1'b1, 32);
    mul_run("mul32 ffff", 1'b0, 32'h0000ffff, 32'h00010001, 32'hffffffff, 1'b0, 1'b0, 1'b0, 32);
    mul_run("mul8 0f", 1'b1, 32'h0f, 32'h11, 32'hff, 1'b0, 1'b0, 1'b0, 8);
    mul_run("mul8 ovf", 1'b1, 32'h10, 32'h10, 32'h00, 1'b1, 1'b1, 1'b1, 8);
    @(negedge clk);
    b32.a = 32'h0000ffff; b32.b = 32'd3; b32.mul = 1'b1; b32.in_valid = 1'b1;
    @(posedge clk);
    #1;
    b32.in_valid = 1'b0; b32.mul = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid-mul busy", {31'b0, b32.busy}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async rst out_valid", {31'b0, b32.out_valid}, 32'd0);
    chk("async rst busy", {31'b0, b32.busy}, 32'd0);
    chk("async rst in_ready", {31'b0, b32.in_ready}, 32'd1);
    chk("async rst result", b32.result, 32'd0);
    chk("async rst flags", {29'b0, b32.overflow, b32.zero, b32.equal}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      seen |= b32.out_valid | b32.busy;
    end
    chk("discarded mul silent", {31'b0, seen}, 32'd0);
    alu_op("post-rst add", '{OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0});
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
